// File: rtl/tpu_skew_feeder_if.sv
// tpu_skew_feeder_if: load, start and skewed-operand bus of the tile feeder
interface tpu_skew_feeder_if #(
  parameter int DIM = 4,
  parameter int BITS_AB = 8
);
  logic wr_vld, wr_rdy, start, mac_en, c_wren, busy, done;
  logic [DIM*BITS_AB-1:0] wr_a, wr_b, a_out, b_out;
  modport master (
    output wr_vld, wr_a, wr_b, start,
    input  wr_rdy, a_out, b_out, mac_en, c_wren, busy, done
  );
  modport slave (
    input  wr_vld, wr_a, wr_b, start,
    output wr_rdy, a_out, b_out, mac_en, c_wren, busy, done
  );
endinterface

// File: rtl/tpu_skew_feeder.sv
// tpu_skew_feeder: buffers a DIMxDIM operand tile and streams it diagonally skewed into a systolic array
module tpu_skew_feeder #(
  parameter int DIM = 4,
  parameter int BITS_AB = 8
) (
  input logic clk,
  input logic rst,
  tpu_skew_feeder_if.slave bus
);
  localparam int W = DIM * BITS_AB;
  localparam int CW = $clog2(DIM + 1);
  localparam int SW = $clog2(3 * DIM);
  localparam logic [CW-1:0] FULL = CW'(DIM);
  localparam logic [SW-1:0] LAST = SW'(3 * DIM - 3);
  typedef enum logic [1:0] {IDLE, CLEAR, STREAM, DONE} state_t;
  state_t state, state_n;
  logic [CW-1:0] load_cnt;
  logic [SW-1:0] step, step_n;
  logic [W-1:0] a_buf [DIM];
  logic [W-1:0] b_buf [DIM];
  logic [W-1:0] a_nx, b_nx;
  logic acc;
  assign bus.wr_rdy = state == IDLE && load_cnt != FULL;
  assign acc = bus.wr_vld && bus.wr_rdy;
  always_comb begin
    state_n = state;
    step_n = '0;
    unique case (state)
      IDLE:   state_n = bus.start && load_cnt == FULL ? CLEAR : IDLE;
      CLEAR:  state_n = STREAM;
      STREAM: begin
        state_n = step == LAST ? DONE : STREAM;
        step_n = step == LAST ? '0 : step + SW'(1);
      end
      default: state_n = IDLE;
    endcase
  end
  // outputs are registered, so the skew is computed from the step about to be shown
  always_comb begin
    a_nx = '0;
    b_nx = '0;
    for (int i = 0; i < DIM; i++)
      for (int k = 0; k < DIM; k++)
        if (state_n == STREAM && int'(step_n) == i + k) begin
          a_nx[i*BITS_AB +: BITS_AB] = a_buf[k][i*BITS_AB +: BITS_AB];
          b_nx[i*BITS_AB +: BITS_AB] = b_buf[k][i*BITS_AB +: BITS_AB];
        end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      step <= '0;
      load_cnt <= '0;
      bus.a_out <= '0;
      bus.b_out <= '0;
      bus.mac_en <= 1'b0;
      bus.c_wren <= 1'b0;
      bus.done <= 1'b0;
      bus.busy <= 1'b0;
    end else begin
      state <= state_n;
      step <= step_n;
      load_cnt <= state_n == DONE ? '0 : acc ? load_cnt + CW'(1) : load_cnt;
      bus.a_out <= a_nx;
      bus.b_out <= b_nx;
      bus.mac_en <= state_n == STREAM;
      bus.c_wren <= state_n == CLEAR;
      bus.done <= state_n == DONE;
      bus.busy <= state_n != IDLE;
    end
  end
  always_ff @(posedge clk) begin
    for (int k = 0; k < DIM; k++)
      if (!rst && acc && load_cnt == CW'(k)) begin
        a_buf[k] <= bus.wr_a;
        b_buf[k] <= bus.wr_b;
      end
  end
endmodule

// File: tb/tb_tpu_skew_feeder.sv
// tb_tpu_skew_feeder: table-driven tiles with a per-cycle scoreboard plus reset/handshake corner cases
module tb_tpu_skew_feeder;
  localparam int DIM = 4;
  localparam int BA = 8;
  typedef struct {
    logic [127:0] a;
    logic [127:0] b;
    int cs;
    logic [31:0] ea;
    logic [31:0] eb;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  tpu_skew_feeder_if #(.DIM(DIM), .BITS_AB(BA)) bus ();
  tpu_skew_feeder #(.DIM(DIM), .BITS_AB(BA)) dut (.clk(clk), .rst(rst), .bus(bus));
  vec_t vt [3];
  logic [7:0] ma [4][4];
  logic [7:0] mb [4][4];
  logic [67:0] sbq [$];
  int tests = 0;
  int fails = 0;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string n, input logic [67:0] act, input logic [67:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", n, act, exp);
    end
  endtask

  function automatic logic [67:0] dut_out();
    return {bus.a_out, bus.b_out, bus.mac_en, bus.c_wren, bus.done, bus.busy};
  endfunction

  task automatic beat(input logic [127:0] a, input logic [127:0] b, input int k);
    chk($sformatf("wr_rdy beat %0d", k), 68'(bus.wr_rdy), 68'd1);
    bus.wr_vld = 1'b1;
    bus.wr_a = a[k*32 +: 32];
    bus.wr_b = b[k*32 +: 32];
    for (int i = 0; i < DIM; i++) begin
      ma[i][k] = a[k*32 + i*8 +: 8];
      mb[k][i] = b[k*32 + i*8 +: 8];
    end
    tick;
    bus.wr_vld = 1'b0;
  endtask

  // expected {a_out, b_out, mac_en, c_wren, done, busy} t cycles after start is taken
  function automatic logic [67:0] model(input int t);
    logic [31:0] ea;
    logic [31:0] eb;
    int s;
    ea = '0;
    eb = '0;
    s = t - 1;
    if (t == 0) return {64'd0, 4'b0101};
    if (t == 11) return {64'd0, 4'b0011};
    for (int i = 0; i < DIM; i++)
      if (s - i >= 0 && s - i < DIM) begin
        ea[i*8 +: 8] = ma[i][s-i];
        eb[i*8 +: 8] = mb[s-i][i];
      end
    return {ea, eb, 4'b1001};
  endfunction

  task automatic run_tile(input int cs, input logic [31:0] ea, input logic [31:0] eb, input bit restart);
    for (int t = 0; t < 12; t++) sbq.push_back(model(t));
    bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
    for (int t = 0; t < 12; t++) begin
      bus.start = restart && t >= 2 && t <= 6;
      chk($sformatf("tile cycle %0d", t), dut_out(), sbq.pop_front());
      if (t == cs + 1) chk("spot lanes", 68'({bus.a_out, bus.b_out}), 68'({ea, eb}));
      tick;
    end
    bus.start = 1'b0;
    chk("idle after done", dut_out(), 68'd0);
    chk("wr_rdy after done", 68'(bus.wr_rdy), 68'd1);
    bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
    chk("start without reload", 68'(bus.busy), 68'd0);
  endtask

  initial begin
    int dn;
    for (int k = 0; k < 4; k++)
      for (int i = 0; i < 4; i++) begin
        vt[0].a[k*32 + i*8 +: 8] = 8'(16 * i + k);
        vt[0].b[k*32 + i*8 +: 8] = 8'(8 * k + i);
        vt[1].a[k*32 + i*8 +: 8] = ((i + k) & 1) != 0 ? 8'h7F : 8'h80;
        vt[1].b[k*32 + i*8 +: 8] = (i & 1) != 0 ? 8'h80 : 8'h7F;
        vt[2].a[k*32 + i*8 +: 8] = 8'($urandom);
        vt[2].b[k*32 + i*8 +: 8] = 8'($urandom);
      end
    vt[0].cs = 3; vt[0].ea = 32'h3021_1203; vt[0].eb = 32'h030A_1118;
    vt[1].cs = 0; vt[1].ea = 32'h0000_0080; vt[1].eb = 32'h0000_007F;
    vt[2].cs = 9; vt[2].ea = 32'h0;         vt[2].eb = 32'h0;
    bus.wr_vld = 1'b0;
    bus.start = 1'b0;
    bus.wr_a = '0;
    bus.wr_b = '0;
    tick;
    tick;
    chk("reset outputs", dut_out(), 68'd0);
    chk("reset wr_rdy", 68'(bus.wr_rdy), 68'd1);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) beat(vt[0].a, vt[0].b, k);
    bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
    chk("start after 3 beats", dut_out(), 68'd0);
    beat(vt[0].a, vt[0].b, 3);
    run_tile(vt[0].cs, vt[0].ea, vt[0].eb, 1'b0);
    for (int e = 1; e < 3; e++) begin
      for (int k = 0; k < 4; k++) beat(vt[e].a, vt[e].b, k);
      run_tile(vt[e].cs, vt[e].ea, vt[e].eb, 1'b0);
    end
    bus.wr_vld = 1'b1;
    for (int c = 0; c < 6; c++) begin
      bus.wr_a = $urandom;
      bus.wr_b = $urandom;
      chk($sformatf("held wr_vld rdy %0d", c), 68'(bus.wr_rdy), c < 4 ? 68'd1 : 68'd0);
      if (c < 4)
        for (int i = 0; i < DIM; i++) begin
          ma[i][c] = bus.wr_a[i*8 +: 8];
          mb[c][i] = bus.wr_b[i*8 +: 8];
        end
      tick;
    end
    bus.wr_vld = 1'b0;
    run_tile(-10, 32'h0, 32'h0, 1'b1);
    for (int k = 0; k < 4; k++) beat(vt[0].a, vt[0].b, k);
    bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
    for (int t = 0; t < 6; t++) tick;
    chk("step 5 before abort", dut_out(), model(6));
    rst = 1'b1;
    bus.start = 1'b1;
    bus.wr_vld = 1'b1;
    tick;
    rst = 1'b0;
    bus.start = 1'b0;
    bus.wr_vld = 1'b0;
    chk("abort outputs", dut_out(), 68'd0);
    chk("abort wr_rdy", 68'(bus.wr_rdy), 68'd1);
    dn = 0;
    for (int t = 0; t < 15; t++) begin
      dn += int'(bus.done);
      tick;
    end
    chk("no done after abort", 68'(dn), 68'd0);
    for (int k = 0; k < 3; k++) beat(vt[1].a, vt[1].b, k);
    bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
    chk("load_cnt cleared by abort", 68'(bus.busy), 68'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
